prio_encoder_drain: RTL

//  Parametrised N-to-log2(N) priority encoder with a valid/ready front and back end.

---
 rtl/prio_encoder_drain.sv | 88 ++++++++
 1 files changed

// File: rtl/prio_encoder_drain.sv
// Priority-ordered drain of a captured request vector: one set-bit index per output beat,
// highest-first (MODE 0) or lowest-first (MODE 1), with valid/ready on both sides.
module prio_encoder_drain #(
  parameter int N    = 8,
  parameter int MODE = 0,
  parameter int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout,
  output logic         out_last,
  output logic         out_none
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t       state, state_next;
  logic [N-1:0] mask, mask_next;
  logic         none_flag, none_next;
  logic [W-1:0] sel;
  logic         single;

  // Later iterations overwrite earlier ones, so the scan direction sets the priority.
  always_comb begin
    sel = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (mask[i]) sel = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (mask[i]) sel = W'(i);
      end
    end
  end

  assign single    = (mask != '0) && ((mask & (mask - N'(1))) == '0);
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DRAIN);
  // On the final beat the mask keeps its last bit, so gate dout outside DRAIN.
  assign dout      = out_valid ? sel : '0;
  assign out_last  = out_valid && (single || none_flag);
  assign out_none  = out_valid && none_flag;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    mask_next  = mask;
    none_next  = none_flag;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mask_next  = din;
          none_next  = (din == '0);
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_last) state_next = IDLE;
          else          mask_next[sel] = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask      <= '0;
      none_flag <= 1'b0;
    end else begin
      state     <= state_next;
      mask      <= mask_next;
      none_flag <= none_next;
    end
  end

endmodule
